// File: rtl/baccarat_sequencer_if.sv
// Score feedback and control outputs between the Baccarat sequencer and its card datapath.
interface baccarat_sequencer_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
  logic       hand_done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, hand_done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, hand_done
  );
endinterface

// File: rtl/baccarat_sequencer.sv
// Moore FSM dealing a Baccarat hand: four-card deal, third-card rules, winner lights.
module baccarat_sequencer (
  input  logic                  slow_clock,
  input  logic                  resetb,
  baccarat_sequencer_if.master  bus
);
  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL1, DEAL_P3, EVAL2, DEAL_D3, DONE
  } state_t;

  state_t state, state_nxt;
  logic   natural;
  logic   banker_draws;
  logic [3:0] v;

  always_ff @(posedge slow_clock) begin
    if (!resetb) state <= DEAL_P1;
    else         state <= state_nxt;
  end

  // Tens and face cards (and an empty slot) are worth zero in the banker table.
  assign v = (bus.pcard3 >= 4'd1 && bus.pcard3 <= 4'd9) ? bus.pcard3 : 4'd0;

  assign natural = (bus.pscore == 4'd8) || (bus.pscore == 4'd9) ||
                   (bus.dscore == 4'd8) || (bus.dscore == 4'd9);

  always_comb begin
    banker_draws = 1'b0;
    case (bus.dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (v != 4'd8);
      4'd4:             banker_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DEAL_P1: state_nxt = DEAL_D1;
      DEAL_D1: state_nxt = DEAL_P2;
      DEAL_P2: state_nxt = DEAL_D2;
      DEAL_D2: state_nxt = EVAL1;
      EVAL1: begin
        if (natural)                   state_nxt = DONE;
        else if (bus.pscore <= 4'd5)   state_nxt = DEAL_P3;
        else if (bus.dscore <= 4'd5)   state_nxt = DEAL_D3;
        else                           state_nxt = DONE;
      end
      DEAL_P3: state_nxt = EVAL2;
      EVAL2:   state_nxt = banker_draws ? DEAL_D3 : DONE;
      DEAL_D3: state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = DEAL_P1;
    endcase
  end

  always_comb begin
    bus.load_pcard1      = (state == DEAL_P1);
    bus.load_dcard1      = (state == DEAL_D1);
    bus.load_pcard2      = (state == DEAL_P2);
    bus.load_dcard2      = (state == DEAL_D2);
    bus.load_pcard3      = (state == DEAL_P3);
    bus.load_dcard3      = (state == DEAL_D3);
    bus.hand_done        = (state == DONE);
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    if (state == DONE) begin
      bus.player_win_light = (bus.pscore > bus.dscore) || (bus.pscore == bus.dscore);
      bus.dealer_win_light = (bus.dscore > bus.pscore) || (bus.pscore == bus.dscore);
    end
  end
endmodule

// File: tb/tb_baccarat_sequencer.sv
// Hand-level bench: table of hands, datapath score model, per-cycle expected-output scoreboard.
module tb_baccarat_sequencer;
  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  baccarat_sequencer_if dp ();

  baccarat_sequencer dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (dp.master)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    string      name;
    logic [3:0] ps1, ds1, pc3, ps2, ds2;
    bit         p3, d3, pw, dw;
    int         hold;
  } hand_t;

  // Output vector: {lp1, ld1, lp2, ld2, lp3, ld3, pw, dw, done}
  localparam logic [8:0] V_P1   = 9'b100000_000;
  localparam logic [8:0] V_D1   = 9'b010000_000;
  localparam logic [8:0] V_P2   = 9'b001000_000;
  localparam logic [8:0] V_D2   = 9'b000100_000;
  localparam logic [8:0] V_P3   = 9'b000010_000;
  localparam logic [8:0] V_D3   = 9'b000001_000;
  localparam logic [8:0] V_IDLE = 9'b000000_000;

  hand_t      tbl [11];
  hand_t      cur;
  logic [8:0] exp_q [$];
  logic [8:0] act;
  logic       p3l, d3l;
  int         total = 0;
  int         bad   = 0;

  assign act = {dp.load_pcard1, dp.load_dcard1, dp.load_pcard2, dp.load_dcard2,
                dp.load_pcard3, dp.load_dcard3, dp.player_win_light,
                dp.dealer_win_light, dp.hand_done};

  // Datapath stand-in: scores switch to their post-draw values once the third cards load.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      p3l <= 1'b0;
      d3l <= 1'b0;
    end else begin
      if (dp.load_pcard3) p3l <= 1'b1;
      if (dp.load_dcard3) d3l <= 1'b1;
    end
  end

  always_comb begin
    dp.pscore = p3l ? cur.ps2 : cur.ps1;
    dp.dscore = d3l ? cur.ds2 : cur.ds1;
    dp.pcard3 = p3l ? cur.pc3 : 4'd0;
  end

  task automatic check_next(input string tag, input int cyc);
    logic [8:0] e;
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", tag, cyc, act, e);
    end
  endtask

  task automatic push_rest(input hand_t h);
    exp_q.push_back(V_D1);
    exp_q.push_back(V_P2);
    exp_q.push_back(V_D2);
    exp_q.push_back(V_IDLE);
    if (h.p3) begin
      exp_q.push_back(V_P3);
      exp_q.push_back(V_IDLE);
    end
    if (h.d3) exp_q.push_back(V_D3);
    for (int i = 0; i < h.hold; i++)
      exp_q.push_back({6'b0, h.pw, h.dw, 1'b1});
  endtask

  // Assumes the DUT currently shows DEAL_P1 with resetb low; releases reset and plays out.
  task automatic play_from_p1(input hand_t h);
    int n;
    push_rest(h);
    n = exp_q.size();
    @(negedge slow_clock) resetb = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge slow_clock);
      #1 check_next(h.name, c);
    end
  endtask

  task automatic run_hand(input hand_t h);
    cur = h;
    @(negedge slow_clock) resetb = 1'b0;
    exp_q.push_back(V_P1);
    @(posedge slow_clock);
    #1 check_next({h.name, "_reset"}, 0);
    play_from_p1(h);
  endtask

  initial begin
    //             name        ps1   ds1   pc3    ps2   ds2   p3 d3 pw dw hold
    tbl[0]  = '{"natural_p8", 4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 0, 0, 1, 0, 3};
    tbl[1]  = '{"p_draw_bst", 4'd4, 4'd3, 4'd8,  4'd2, 4'd3, 1, 0, 0, 1, 3};
    tbl[2]  = '{"face_zero",  4'd5, 4'd6, 4'd12, 4'd5, 4'd6, 1, 0, 0, 1, 3};
    tbl[3]  = '{"p3_seven",   4'd5, 4'd6, 4'd7,  4'd2, 4'd8, 1, 1, 0, 1, 3};
    tbl[4]  = '{"p_st_b_drw", 4'd6, 4'd5, 4'd0,  4'd6, 4'd7, 0, 1, 0, 1, 3};
    tbl[5]  = '{"tie_hold",   4'd7, 4'd7, 4'd0,  4'd7, 4'd7, 0, 0, 1, 1, 11};
    tbl[6]  = '{"natural_d9", 4'd2, 4'd9, 4'd0,  4'd2, 4'd9, 0, 0, 0, 1, 3};
    tbl[7]  = '{"b_zero_ten", 4'd3, 4'd0, 4'd10, 4'd3, 4'd4, 1, 1, 0, 1, 3};
    tbl[8]  = '{"b4_ace",     4'd0, 4'd4, 4'd1,  4'd1, 4'd4, 1, 0, 0, 1, 3};
    tbl[9]  = '{"b3_king",    4'd5, 4'd3, 4'd13, 4'd5, 4'd5, 1, 1, 1, 1, 3};
    tbl[10] = '{"nat_tie99",  4'd9, 4'd9, 4'd0,  4'd9, 4'd9, 0, 0, 1, 1, 3};

    for (int i = 0; i < 11; i++) run_hand(tbl[i]);

    // Mid-hand reset while in DEAL_P3, then a full replay of the same hand.
    cur = tbl[1];
    @(negedge slow_clock) resetb = 1'b0;
    exp_q.push_back(V_P1);
    @(posedge slow_clock);
    #1 check_next("mid_reset_pre", 0);
    exp_q.push_back(V_D1);
    exp_q.push_back(V_P2);
    exp_q.push_back(V_D2);
    exp_q.push_back(V_IDLE);
    exp_q.push_back(V_P3);
    @(negedge slow_clock) resetb = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge slow_clock);
      #1 check_next("mid_deal", c);
    end
    @(negedge slow_clock) resetb = 1'b0;
    exp_q.push_back(V_P1);
    @(posedge slow_clock);
    #1 check_next("mid_reset_hit", 0);
    play_from_p1(tbl[1]);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
